// File: rtl/ram_fifo_leveled.sv
// Leveled FIFO on an inferred synchronous RAM with registered flags and pop data.
// Optional sticky overflow/underflow flags: define RAM_FIFO_ERR_FLAGS_EN.
module ram_fifo_leveled #(
  parameter int DAT_WID        = 24,
  parameter int FIFO_DEPTH     = 1500,
  parameter int FIFO_DEPTH_WID = 11,
  parameter int AFULL_LVL      = FIFO_DEPTH - 4,
  parameter int AEMPTY_LVL     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      write_enable,
  input  logic [DAT_WID-1:0]        write_dat,
  input  logic                      read_enable,
  output logic [DAT_WID-1:0]        read_dat,
  output logic                      read_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [FIFO_DEPTH_WID-1:0] level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam logic [FIFO_DEPTH_WID-1:0] DEPTH_L =
    FIFO_DEPTH_WID'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WID-1:0] LAST_L =
    FIFO_DEPTH_WID'(FIFO_DEPTH - 1);
  localparam logic [FIFO_DEPTH_WID-1:0] AFULL_L =
    FIFO_DEPTH_WID'(AFULL_LVL);
  localparam logic [FIFO_DEPTH_WID-1:0] AEMPTY_L =
    FIFO_DEPTH_WID'(AEMPTY_LVL);
  localparam logic [FIFO_DEPTH_WID-1:0] ONE_L =
    FIFO_DEPTH_WID'(1);

  logic [DAT_WID-1:0]        mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_WID-1:0] wr_ptr;
  logic [FIFO_DEPTH_WID-1:0] rd_ptr;
  logic [FIFO_DEPTH_WID-1:0] wr_ptr_nxt;
  logic [FIFO_DEPTH_WID-1:0] rd_ptr_nxt;
  logic [FIFO_DEPTH_WID-1:0] level_q;
  logic [FIFO_DEPTH_WID-1:0] level_nxt;
  logic                      rd_acc;
  logic                      wr_acc;
  logic                      rd_go;
  logic                      wr_go;

  // A write into a full FIFO is legal when a pop frees a slot in the same cycle.
  assign rd_acc = read_enable & ~empty;
  assign wr_acc = write_enable & (~full | rd_acc);
  assign rd_go  = rd_acc & ~clear;
  assign wr_go  = wr_acc & ~clear;

  assign wr_ptr_nxt = (wr_ptr == LAST_L) ? '0 : wr_ptr + ONE_L;
  assign rd_ptr_nxt = (rd_ptr == LAST_L) ? '0 : rd_ptr + ONE_L;

  always_comb begin
    level_nxt = level_q;
    unique case (1'b1)
      clear:            level_nxt = '0;
      wr_go & ~rd_go:   level_nxt = level_q + ONE_L;
      rd_go & ~wr_go:   level_nxt = level_q - ONE_L;
      default:          level_nxt = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      read_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_go) wr_ptr <= wr_ptr_nxt;
        if (rd_go) rd_ptr <= rd_ptr_nxt;
      end
      level_q      <= level_nxt;
      read_valid   <= rd_go;
      full         <= (level_nxt == DEPTH_L);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AFULL_L);
      almost_empty <= (level_nxt <= AEMPTY_L);
    end
  end

  assign level = level_q;

  // RAM array carries no reset so it maps onto block memory.
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= write_dat;
  end

  // Read-before-write: a full-FIFO push+pop on one slot returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_dat <= '0;
    end else if (rd_go) begin
      read_dat <= mem[rd_ptr];
    end
  end

`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (write_enable & ~wr_acc) ovf_q <= 1'b1;
      if (read_enable & empty)    unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ram_fifo_leveled.sv
// Directed bench for ram_fifo_leveled (depth 6) with a queue-based reference model.
// Error-flag expectations follow RAM_FIFO_ERR_FLAGS_EN.
module tb_ram_fifo_leveled;

  localparam int DW = 24;
  localparam int D  = 6;
  localparam int W  = 11;
  localparam int AF = 4;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          write_enable;
  logic [DW-1:0] write_dat;
  logic          read_enable;
  logic [DW-1:0] read_dat;
  logic          read_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [W-1:0]  level;
  logic          overflow;
  logic          underflow;

  always #5 clk = ~clk;

  ram_fifo_leveled #(
    .DAT_WID(DW),
    .FIFO_DEPTH(D),
    .FIFO_DEPTH_WID(W),
    .AFULL_LVL(AF),
    .AEMPTY_LVL(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .write_enable(write_enable),
    .write_dat(write_dat),
    .read_enable(read_enable),
    .read_dat(read_dat),
    .read_valid(read_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .level(level),
    .overflow(overflow),
    .underflow(underflow)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_dat;
  logic          exp_valid;
  logic          m_ovf;
  logic          m_unf;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int lv;
    logic [DW-1:0] e;
    lv = mdl_q.size();
    chk({tag, ".read_valid"}, 32'(read_valid), 32'(exp_valid));
    if (exp_valid) begin
      e = exp_q.pop_front();
      chk({tag, ".read_dat"}, 32'(read_dat), 32'(e));
      last_dat = e;
    end else begin
      chk({tag, ".read_dat_hold"}, 32'(read_dat), 32'(last_dat));
    end
    chk({tag, ".level"}, 32'(level), 32'(lv));
    chk({tag, ".full"}, 32'(full), 32'(lv == D));
    chk({tag, ".empty"}, 32'(empty), 32'(lv == 0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(lv >= AF));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(lv <= AE));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    last_dat  = '0;
    exp_valid = 1'b0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
  endtask

  task automatic step(input string tag,
                      input logic we,
                      input logic [DW-1:0] wd,
                      input logic re,
                      input logic clr);
    int lv;
    bit rd_acc;
    bit wr_acc;
    write_enable = we;
    write_dat    = wd;
    read_enable  = re;
    clear        = clr;
    lv     = mdl_q.size();
    rd_acc = re && (lv != 0);
    wr_acc = we && ((lv != D) || rd_acc);
    exp_valid = 1'b0;
    if (clr) begin
      mdl_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_acc) begin
        exp_q.push_back(mdl_q.pop_front());
        exp_valid = 1'b1;
      end
      if (wr_acc) mdl_q.push_back(wd);
`ifdef RAM_FIFO_ERR_FLAGS_EN
      if (we && !wr_acc) m_ovf = 1'b1;
      if (re && lv == 0) m_unf = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    clear        = 1'b0;
    write_dat    = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    clear        = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    write_dat    = '0;
    model_reset();
    #2;
    do_reset();

    // Five writes then five reads, order preserved.
    for (int i = 1; i <= 5; i++) step("wr5", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("rd5", 1'b0, '0, 1'b1, 1'b0);
    step("idle", 1'b0, '0, 1'b0, 1'b0);

    // Underflow attempt on an empty FIFO.
    step("unf", 1'b0, '0, 1'b1, 1'b0);
    do_reset();

    // Fill to full walking through both thresholds, then overflow.
    for (int i = 0; i < D; i++)
      step("fill", 1'b1, DW'(24'hA00 + i), 1'b0, 1'b0);
    step("ovf", 1'b1, 24'hBAD, 1'b0, 1'b0);
    step("full_wr_rd", 1'b1, 24'hC00, 1'b1, 1'b0);
    for (int i = 0; i < D; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    do_reset();

    // Hold level at 3 through pointer wrap.
    for (int i = 0; i < 3; i++)
      step("pre3", 1'b1, DW'(24'h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step("wrap", 1'b1, DW'(24'h200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("post3", 1'b0, '0, 1'b1, 1'b0);
    do_reset();

    // Simultaneous push/pop on empty: no fall-through.
    step("wr_rd_empty", 1'b1, 24'h5A5A5A, 1'b1, 1'b0);
    step("rd_after", 1'b0, '0, 1'b1, 1'b0);

    // Clear at level 3 with a read pending.
    for (int i = 0; i < 3; i++)
      step("clr_fill", 1'b1, DW'(24'h300 + i), 1'b0, 1'b0);
    step("clear", 1'b1, 24'h777, 1'b1, 1'b1);
    step("post_clr", 1'b0, '0, 1'b0, 1'b0);

    // Reset lands just after a read was accepted.
    for (int i = 0; i < 3; i++)
      step("rst_fill", 1'b1, DW'(24'h400 + i), 1'b0, 1'b0);
    write_enable = 1'b0;
    read_enable  = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    read_enable = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_midread");
    @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst = 1'b0;
    step("rst_rel0", 1'b0, '0, 1'b0, 1'b0);
    step("rst_rel1", 1'b0, '0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_leveled.md
RAM_FIFO_LEVELED -- requirements
Module: ram_fifo_leveled

Interface
REQ-001 SHALL have parameter DAT_WID, default 24, data word width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 1500, number of storage words; any value 2..2^FIFO_DEPTH_WID-1, need not be a power of 2.
REQ-003 SHALL have parameter FIFO_DEPTH_WID, default 11, width of pointers and level.
REQ-004 SHALL have parameters AFULL_LVL, default FIFO_DEPTH-4, and AEMPTY_LVL, default 4, both programmable flag thresholds.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port clear, input, 1, synchronous flush request.
REQ-008 SHALL have ports write_enable, input, 1, push request, and write_dat, input, DAT_WID, push data.
REQ-009 SHALL have ports read_enable, input, 1, pop request, and read_dat, output, DAT_WID, registered pop data.
REQ-010 SHALL have port read_valid, output, 1, high for one cycle when read_dat carries a newly popped word.
REQ-011 SHALL have ports full, empty, almost_full, almost_empty, outputs, 1 each, registered status flags.
REQ-012 SHALL have port level, output, FIFO_DEPTH_WID, current stored word count.
REQ-013 SHALL have ports overflow and underflow, outputs, 1 each, sticky error flags (see Configuration).

Function
REQ-014 SHALL store words in an inferred synchronous RAM of FIFO_DEPTH x DAT_WID; no reset on RAM contents.
REQ-015 SHALL accept a write when write_enable=1 and (full=0 or read accepted same cycle).
REQ-016 SHALL accept a read when read_enable=1 and empty=0.
REQ-017 SHALL present accepted-read data on read_dat with read_valid=1 exactly one cycle after the accepting edge; read_dat holds its value otherwise.
REQ-018 SHALL advance write and read pointers independently, wrapping from FIFO_DEPTH-1 to 0.
REQ-019 SHALL update level: +1 write only, -1 read only, unchanged for both or neither; level never exceeds FIFO_DEPTH.
REQ-020 SHALL on write+read while empty accept only the write (no fall-through); read_valid stays 0.
REQ-021 SHALL on write+read while full accept both; level stays FIFO_DEPTH, full stays 1.
REQ-022 SHALL drive full=(level==FIFO_DEPTH), empty=(level==0), almost_full=(level>=AFULL_LVL), almost_empty=(level<=AEMPTY_LVL), all consistent with level in the same cycle.
REQ-023 SHALL on clear=1 zero pointers and level, set empty/almost_empty, clear read_valid, ignore same-cycle read/write; read_dat keeps its value.

Reset
REQ-024 SHALL on rst=1 asynchronously force pointers=0, level=0, read_dat=0, read_valid=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0.
REQ-025 SHALL abort any in-flight read on reset; no read_valid pulse after rst deasserts unless a new read is accepted.

Configuration
REQ-026 SHALL with macro RAM_FIFO_ERR_FLAGS_EN defined set overflow on write_enable=1 rejected by full, set underflow on read_enable=1 while empty, both sticky until rst or clear.
REQ-027 SHALL without RAM_FIFO_ERR_FLAGS_EN tie overflow and underflow to 0 and synthesise no error logic.

Verification
REQ-028 SHALL cover: reset, write 0x000001..0x000005 on 5 cycles, then 5 reads -> read_dat 0x000001..0x000005 in order, read_valid one cycle after each read, empty=1 at end.
REQ-029 SHALL cover: FIFO_DEPTH=6, write 6 words -> full=1, level=6; 7th write dropped, overflow=1 (macro on) / 0 (macro off); subsequent reads return the 6 original words.
REQ-030 SHALL cover: FIFO_DEPTH=6, 20 cycles of simultaneous write/read with level held at 3 -> pointers wrap, data order preserved, level constant 3.
REQ-031 SHALL cover: empty FIFO, write+read same cycle -> level=1, read_valid=0; next-cycle read returns written word.
REQ-032 SHALL cover: AFULL_LVL=4, AEMPTY_LVL=1, fill 0->6 -> almost_empty drops at level 2, almost_full rises at level 4.
REQ-033 SHALL cover: level=3, assert clear then rst mid-read -> level=0, empty=1, read_valid=0 following cycle, no stale read_valid after release.
